// File: rtl/seg7_cmd_pkg.sv
// Shared constants for the 7-segment command controller.
// Holds opcode values, FSM state encoding, the "no colon" code and a
// single-digit BCD increment helper used by the optional incrementer.
package seg7_cmd_pkg;

  typedef logic [1:0] state_t;

  // Command opcodes (first byte of a frame)
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_COLON = 8'h02;
  localparam logic [7:0] OP_INC   = 8'h03;
  localparam logic [7:0] OP_CLEAR = 8'h04;
  localparam logic [7:0] OP_BLANK = 8'h05;

  // FSM state encoding
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PAY1  = 2'd1;
  localparam state_t ST_PAY2  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  localparam logic [1:0] COLON_NONE = 2'b11;

  // Returns {carry, digit} for one digit incremented by one. Any value of 9
  // or above (including non-BCD nibbles) rolls to 0 and carries.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
    if (d >= 4'd9) begin
      return {1'b1, 4'd0};
    end
    return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/bcd4_incr.sv
// Combinational 4-digit BCD +1.
// Ports:
//   digits_in  [15:0] {digit3, digit2, digit1, digit0}
//   digits_out [15:0] incremented value (wraps to 0000 on overflow)
//   carry_out         set when the increment carried out of digit3
module bcd4_incr
  import seg7_cmd_pkg::*;
(
  input  logic [15:0] digits_in,
  output logic [15:0] digits_out,
  output logic        carry_out
);

  always_comb begin
    logic       carry;
    logic [4:0] step;
    carry      = 1'b1;
    step       = '0;
    digits_out = '0;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        step                 = bcd_digit_inc(digits_in[4*i +: 4]);
        digits_out[4*i +: 4] = step[3:0];
        carry                = step[4];
      end else begin
        digits_out[4*i +: 4] = digits_in[4*i +: 4];
      end
    end
    carry_out = carry;
  end

endmodule

// File: rtl/seg7_cmd_ctrl.sv
// Command controller between the SPI byte receiver and the 4-digit
// 7-segment driver. Decodes framed command bytes and commits each command
// in one clock edge so the scanning driver never sees a partial update.
//
// Optional feature macro: SEG7_CMD_INC_EN (compiles in opcode 0x03 INC and
// the BCD incrementer; without it 0x03 is an illegal opcode).
//
// Parameters:
//   RST_COLON  colon code loaded at reset and by CLEAR
//   BCD_WRAP   1: INC wraps 9999->0000, 0: INC saturates at 9999
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rx_valid, rx_data  received-byte strobe and byte
//   cs_active          frame qualifier (synchronous to clk)
//   digit0..digit3     display digits (digit0 least significant)
//   colon, blank       colon code, display blank
//   cmd_done, cmd_err  one-cycle commit / illegal-opcode pulses
module seg7_cmd_ctrl
  import seg7_cmd_pkg::*;
#(
  parameter logic [1:0] RST_COLON = COLON_NONE,
  parameter bit         BCD_WRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       cs_active,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] colon,
  output logic       blank,
  output logic       cmd_done,
  output logic       cmd_err
);

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;       // opcode of the frame in progress
  logic [7:0]  pay_q, pay_d;     // first WRITE payload byte (shadow)
  logic [15:0] digits_q, digits_d;
  logic [1:0]  colon_q, colon_d;
  logic        blank_q, blank_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

`ifdef SEG7_CMD_INC_EN
  logic [15:0] inc_sum;
  logic        inc_carry;
  logic [15:0] inc_digits;

  bcd4_incr u_incr (
    .digits_in  (digits_q),
    .digits_out (inc_sum),
    .carry_out  (inc_carry)
  );

  // Saturation pins all digits at 9 rather than holding the old value,
  // which matters when non-BCD nibbles were written.
  assign inc_digits = (inc_carry && !BCD_WRAP) ? 16'h9999 : inc_sum;
`else
  logic unused_bcd_wrap;
  assign unused_bcd_wrap = BCD_WRAP;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pay_d    = pay_q;
    digits_d = digits_q;
    colon_d  = colon_q;
    blank_d  = blank_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (!cs_active) begin
      // Frame end or abort: shadow state is simply abandoned.
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          op_d    = rx_data;
          state_d = ST_DRAIN;
          case (rx_data)
            OP_WRITE, OP_COLON, OP_BLANK: state_d = ST_PAY1;
`ifdef SEG7_CMD_INC_EN
            OP_INC: begin
              digits_d = inc_digits;
              done_d   = 1'b1;
            end
`endif
            OP_CLEAR: begin
              digits_d = '0;
              colon_d  = RST_COLON;
              blank_d  = 1'b0;
              done_d   = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
        ST_PAY1: begin
          state_d = ST_DRAIN;
          case (op_q)
            OP_WRITE: begin
              pay_d   = rx_data;
              state_d = ST_PAY2;
            end
            OP_COLON: begin
              colon_d = rx_data[1:0];
              done_d  = 1'b1;
            end
            OP_BLANK: begin
              blank_d = rx_data[0];
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_PAY2: begin
          digits_d = {pay_q, rx_data};
          done_d   = 1'b1;
          state_d  = ST_DRAIN;
        end
        ST_DRAIN: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      pay_q    <= '0;
      digits_q <= '0;
      colon_q  <= RST_COLON;
      blank_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pay_q    <= pay_d;
      digits_q <= digits_d;
      colon_q  <= colon_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign digit0   = digits_q[3:0];
  assign digit1   = digits_q[7:4];
  assign digit2   = digits_q[11:8];
  assign digit3   = digits_q[15:12];
  assign colon    = colon_q;
  assign blank    = blank_q;
  assign cmd_done = done_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_seg7_cmd_ctrl.sv
// Directed self-checking bench for seg7_cmd_ctrl.
module tb_seg7_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cs_active;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [1:0] colon;
  logic       blank, cmd_done, cmd_err;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  seg7_cmd_ctrl #(
    .RST_COLON (2'b11),
    .BCD_WRAP  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cs_active (cs_active),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .colon     (colon),
    .blank     (blank),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err)
  );

`ifdef SEG7_CMD_INC_EN
  logic [3:0] s_d0, s_d1, s_d2, s_d3;
  logic [1:0] s_colon;
  logic       s_blank, s_done, s_err;

  seg7_cmd_ctrl #(
    .RST_COLON (2'b11),
    .BCD_WRAP  (1'b0)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cs_active (cs_active),
    .digit0    (s_d0),
    .digit1    (s_d1),
    .digit2    (s_d2),
    .digit3    (s_d3),
    .colon     (s_colon),
    .blank     (s_blank),
    .cmd_done  (s_done),
    .cmd_err   (s_err)
  );
`endif

  function automatic logic [15:0] digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one cycle; returns #1 after the capturing edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic frame_end();
    cs_active = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cs_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits", {16'h0, digits()}, 32'h0000);
    check("rst_colon", {30'h0, colon}, 32'h3);
    check("rst_blank", {31'h0, blank}, 32'h0);
    check("rst_done", {31'h0, cmd_done}, 32'h0);
    check("rst_err", {31'h0, cmd_err}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // WRITE 1234, back-to-back bytes
    cs_active = 1'b1;
    send(8'h01);
    send(8'h12);
    check("wr_no_early_done", {31'h0, cmd_done}, 32'h0);
    check("wr_no_early_digits", {16'h0, digits()}, 32'h0000);
    send(8'h34);
    check("wr_digits", {16'h0, digits()}, 32'h1234);
    check("wr_done", {31'h0, cmd_done}, 32'h1);
    @(posedge clk);
    #1;
    check("wr_done_once", {31'h0, cmd_done}, 32'h0);
    frame_end();

    // Aborted WRITE
    cs_active = 1'b1;
    send(8'h01);
    send(8'h56);
    cs_active = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done", {31'h0, cmd_done}, 32'h0);
    check("abort_digits", {16'h0, digits()}, 32'h1234);

    // COLON 01 right after the abort
    cs_active = 1'b1;
    send(8'h02);
    send(8'h01);
    check("colon_val", {30'h0, colon}, 32'h1);
    check("colon_done", {31'h0, cmd_done}, 32'h1);
    frame_end();

    // Illegal opcode
    cs_active = 1'b1;
    send(8'h7F);
    check("bad_err", {31'h0, cmd_err}, 32'h1);
    send(8'h00);
    check("bad_err_once", {31'h0, cmd_err}, 32'h0);
    check("bad_no_done", {31'h0, cmd_done}, 32'h0);
    check("bad_digits", {16'h0, digits()}, 32'h1234);
    check("bad_colon", {30'h0, colon}, 32'h1);
    frame_end();

`ifdef SEG7_CMD_INC_EN
    cs_active = 1'b1;
    send(8'h03);
    check("inc_1234", {16'h0, digits()}, 32'h1235);
    check("inc_done", {31'h0, cmd_done}, 32'h1);
    frame_end();
    cs_active = 1'b1;
    send(8'h01); send(8'h09); send(8'h99);
    frame_end();
    cs_active = 1'b1;
    send(8'h03);
    check("inc_0999", {16'h0, digits()}, 32'h1000);
    frame_end();
    cs_active = 1'b1;
    send(8'h01); send(8'h99); send(8'h99);
    frame_end();
    cs_active = 1'b1;
    send(8'h03);
    check("inc_wrap", {16'h0, digits()}, 32'h0000);
    check("inc_sat", {16'h0, s_d3, s_d2, s_d1, s_d0}, 32'h9999);
    frame_end();
    cs_active = 1'b1;
    send(8'h01); send(8'h12); send(8'h34);
    frame_end();
`else
    cs_active = 1'b1;
    send(8'h03);
    check("inc_off_err", {31'h0, cmd_err}, 32'h1);
    check("inc_off_done", {31'h0, cmd_done}, 32'h0);
    check("inc_off_digits", {16'h0, digits()}, 32'h1234);
    frame_end();
`endif

    // BLANK with a trailing byte that must be ignored
    cs_active = 1'b1;
    send(8'h05);
    send(8'h01);
    check("blank_val", {31'h0, blank}, 32'h1);
    check("blank_done", {31'h0, cmd_done}, 32'h1);
    send(8'h04);
    check("drain_no_done", {31'h0, cmd_done}, 32'h0);
    check("drain_no_err", {31'h0, cmd_err}, 32'h0);
    check("drain_digits", {16'h0, digits()}, 32'h1234);
    check("drain_blank", {31'h0, blank}, 32'h1);
    frame_end();

    // CLEAR
    cs_active = 1'b1;
    send(8'h04);
    check("clr_digits", {16'h0, digits()}, 32'h0000);
    check("clr_colon", {30'h0, colon}, 32'h3);
    check("clr_blank", {31'h0, blank}, 32'h0);
    check("clr_done", {31'h0, cmd_done}, 32'h1);
    frame_end();

    // Reload 1234, then bytes with cs_active low must do nothing
    cs_active = 1'b1;
    send(8'h01); send(8'h12); send(8'h34);
    frame_end();
    send(8'h04);
    check("cs_low_digits", {16'h0, digits()}, 32'h1234);
    check("cs_low_done", {31'h0, cmd_done}, 32'h0);
    send(8'h02);
    cs_active = 1'b1;
    send(8'h02);
    send(8'h00);
    check("cs_low_idle_colon", {30'h0, colon}, 32'h0);
    check("cs_low_idle_done", {31'h0, cmd_done}, 32'h1);
    frame_end();

    // Reset while in PAY2
    cs_active = 1'b1;
    send(8'h01);
    send(8'hAB);
    #2;
    rst = 1'b1;
    #1;
    check("rst_pay2_digits", {16'h0, digits()}, 32'h0000);
    check("rst_pay2_colon", {30'h0, colon}, 32'h3);
    check("rst_pay2_blank", {31'h0, blank}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Still in frame: next byte is taken as an opcode, not as WRITE payload
    send(8'hCD);
    check("rst_pay2_idle_err", {31'h0, cmd_err}, 32'h1);
    check("rst_pay2_idle_digits", {16'h0, digits()}, 32'h0000);
    frame_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_cmd_ctrl.md
# seg7_cmd_ctrl

Command controller between the SPI byte receiver and the 4-digit 7-segment driver. Decodes framed SPI command bytes (opcode plus payload) into the display's digit, colon and blank registers, and commits each command atomically so the scanning driver never shows a half-written value. Replaces the ad-hoc per-byte digit increment with a defined register protocol.

## Interface
- RST_COLON, 2'b11: colon/decimal-point code loaded at reset and by CLEAR (00 colon, 01 decpoint, 11 none).
- BCD_WRAP, 1: 1 means INC wraps 9999 to 0000; 0 means INC saturates at 9999.

Ports:
- clk  in  1  system clock (WF_CLK domain).
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received SPI byte.
- cs_active  in  1  frame qualifier, already synchronised to clk; high while chip select is asserted.
- digit0..digit3  out  4 each  display digits, digit0 is the least significant digit.
- colon  out  2  colon/decimal-point code.
- blank  out  1  1 blanks the display.
- cmd_done  out  1  one-cycle pulse on the cycle a command commits.
- cmd_err  out  1  one-cycle pulse on an illegal opcode.

## Operation
- Opcodes (first byte of a frame):
  - 0x01 WRITE: 2 payload bytes, {digit3,digit2} then {digit1,digit0}.
  - 0x02 COLON: 1 payload byte; bits[1:0] go to colon.
  - 0x03 INC: no payload; BCD +1 across 4 digits.
  - 0x04 CLEAR: no payload; digits 0, colon RST_COLON, blank 0.
  - 0x05 BLANK: 1 payload byte; bit0 goes to blank.
- States:
  - IDLE: waits for the first byte of a frame.
  - PAY1, PAY2: collect payload bytes into shadow registers.
  - DRAIN: ignores all further bytes until the frame ends.
- Transitions:
  - IDLE + byte: a no-payload opcode commits and goes to DRAIN; a payload opcode goes to PAY1; an unknown opcode pulses cmd_err and goes to DRAIN.
  - PAY1 + byte: WRITE goes to PAY2; COLON and BLANK commit and go to DRAIN.
  - PAY2 + byte: WRITE commits and goes to DRAIN.
  - Any state: cs_active low forces IDLE.
- Only one command per frame. Extra bytes in DRAIN are ignored silently, with no error.
- Frame abort (cs_active falls in PAY1 or PAY2): shadow registers are discarded and outputs stay unchanged.
- rx_valid while cs_active is low is ignored.
- If rx_valid and a cs_active low sample coincide, the byte is ignored.
- WRITE nibbles are stored verbatim; no BCD check is made.
- INC arithmetic:
  - Per digit, a value of 9 or more becomes 0 and carries; otherwise the digit increments.
  - Carry out of digit3 follows BCD_WRAP: wrap to 0000, or saturate so all digits hold 9.
- Reset values: digits 0, colon RST_COLON, blank 0, cmd_done 0, cmd_err 0, state IDLE.
- Reset is asynchronous. Asserting it mid-frame drops the frame; after release the controller waits in IDLE.

## Timing
- Commit latency: outputs and cmd_done change on the clock edge following the rx_valid cycle of the final command byte. This is 1 cycle.
- cmd_err is asserted in the cycle after the rx_valid of the bad opcode.
- All outputs are registered, with no combinational path from input to output.
- Back-to-back rx_valid on consecutive cycles must be accepted.
- The cs_active low to IDLE transition takes 1 cycle.
- The minimum frame gap is 1 cycle of cs_active low.

## Configuration
- SEG7_CMD_INC_EN:
  - Defined: opcode 0x03 INC and the BCD incrementer are compiled in.
  - Undefined: 0x03 is treated as an unknown opcode (cmd_err pulse, go to DRAIN); no incrementer logic is present, and BCD_WRAP is unused.

## Structure
- seg7_cmd_pkg holds:
  - opcode localparams (OP_WRITE, OP_COLON, OP_INC, OP_CLEAR, OP_BLANK);
  - the state encoding (ST_IDLE, ST_PAY1, ST_PAY2, ST_DRAIN);
  - COLON_NONE = 2'b11.
- Sub-module bcd4_incr: combinational 4-digit BCD +1 with carry-out, instantiated only under SEG7_CMD_INC_EN.

## Test plan
- Reset, then frame 0x01,0x12,0x34 -> digits 3..0 = 1,2,3,4; cmd_done pulses once, 1 cycle after the 3rd byte.
- Digits at 0999, frame 0x03 -> 1000. Digits at 9999 with BCD_WRAP=1 -> 0000; with BCD_WRAP=0 -> 9999.
- Frame 0x01,0x56, then cs_active drops -> digits unchanged and no cmd_done. The next frame 0x02,0x01 sets colon to 01.
- Frame 0x7F,0x00 -> cmd_err pulses once, outputs unchanged. With SEG7_CMD_INC_EN undefined, 0x03 -> cmd_err.
- Frame 0x05,0x01,0x04 -> blank=1 and the trailing 0x04 is ignored. The next frame 0x04 -> digits 0, colon 11, blank 0.
- rst asserted while in PAY2 -> all outputs at reset values immediately. rx_valid with cs_active low -> no effect.
